// File: rtl/hazard_pkg.sv
// Shared types and constants for the N-lane hazard unit.
package hazard_pkg;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_BUSY = 1'b1
    } mult_state_t;

    localparam int unsigned REG_ZERO  = 0;
    localparam int unsigned DEF_LANES = 2;
    localparam int unsigned DEF_REG_W = 5;

endpackage

// File: rtl/hazard_unit_nw_lane_match.sv
// Load-use match for one decode lane against every execute lane.
module lane_match
    import hazard_pkg::*;
#(
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned REG_W = DEF_REG_W
) (
    input  logic [LANES-1:0]       MemToRegE,
    input  logic [LANES*REG_W-1:0] RegDstE,
    input  logic [REG_W-1:0]       RsD,
    input  logic [REG_W-1:0]       RtD,
    output logic                   match
);

    logic [REG_W-1:0] dst;

    // OR together matches from all execute lanes; $0 never matches
    always_comb begin
        match = 1'b0;
        dst   = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            dst = RegDstE[l*REG_W +: REG_W];
            if (MemToRegE[l] && (dst != REG_W'(REG_ZERO)) &&
                ((dst == RsD) || (dst == RtD))) begin
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_unit_nw.sv
// N-lane load-use / HI-LO hazard unit with programmable flush hold
// and a saturating stall-cycle counter.
module hazard_unit_nw
    import hazard_pkg::*;
#(
    parameter int unsigned LANES        = DEF_LANES,
    parameter int unsigned REG_W        = DEF_REG_W,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES-1:0]       MemToRegE,
    input  logic [LANES*REG_W-1:0] RegDstE,
    input  logic [LANES*REG_W-1:0] RsD,
    input  logic [LANES*REG_W-1:0] RtD,
    input  logic [LANES-1:0]       HiLoReadD,
    input  logic                   Start_mult,
    input  logic                   mult_ready,
    input  logic                   BTFlush,
    input  logic                   JFlush,
    output logic                   stall,
    output logic                   flush,
    output logic [LANES-1:0]       hazard_lane,
    output logic                   mult_busy,
    output logic [CNT_W-1:0]       stall_cycles
);

    localparam int unsigned     FC_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

    mult_state_t     mstate;
    logic [FC_W-1:0] fcnt;
    logic [LANES-1:0] match;
    logic            redirect;
    logic            hilo_hazard;

    genvar j;
    generate
        for (j = 0; j < LANES; j++) begin : g_lane
            lane_match #(
                .LANES (LANES),
                .REG_W (REG_W)
            ) u_match (
                .MemToRegE (MemToRegE),
                .RegDstE   (RegDstE),
                .RsD       (RsD[j*REG_W +: REG_W]),
                .RtD       (RtD[j*REG_W +: REG_W]),
                .match     (match[j])
            );
        end
    endgenerate

    // Combinational hazard outputs; reset low forces them all to zero
    // even though the inputs are not gated upstream.
    always_comb begin
        redirect    = BTFlush | JFlush;
        mult_busy   = (mstate == M_BUSY);
        flush       = reset & (redirect | (fcnt != '0));
        hazard_lane = (reset && !flush) ? match : '0;
        hilo_hazard = mult_busy & (|HiLoReadD);
        stall       = reset & !flush & ((|hazard_lane) | hilo_hazard);
    end

    // Multiplier tracking FSM; independent of flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mstate <= M_IDLE;
        end else begin
            case (mstate)
                M_IDLE:  if (Start_mult && !mult_ready) mstate <= M_BUSY;
                M_BUSY:  if (mult_ready) mstate <= M_IDLE;
                default: mstate <= M_IDLE;
            endcase
        end
    end

    // Flush hold counter; redirect reloads even mid-countdown
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcnt <= '0;
        end else if (redirect) begin
            fcnt <= FC_LOAD;
        end else if (fcnt != '0) begin
            fcnt <= fcnt - 1'b1;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit_nw.sv
// Directed testbench for hazard_unit_nw: a FLUSH_CYCLES=3 instance and a
// FLUSH_CYCLES=1, CNT_W=4 instance share the same stimulus.
module tb_hazard_unit_nw;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  MemToRegE;
    logic [9:0]  RegDstE;
    logic [9:0]  RsD;
    logic [9:0]  RtD;
    logic [1:0]  HiLoReadD;
    logic        Start_mult;
    logic        mult_ready;
    logic        BTFlush;
    logic        JFlush;

    logic        stall, flush, mult_busy;
    logic [1:0]  hazard_lane;
    logic [15:0] stall_cycles;

    logic        stall_b, flush_b, mult_busy_b;
    logic [1:0]  hazard_lane_b;
    logic [3:0]  stall_cycles_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit_nw #(
        .LANES        (2),
        .REG_W        (5),
        .FLUSH_CYCLES (3),
        .CNT_W        (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemToRegE    (MemToRegE),
        .RegDstE      (RegDstE),
        .RsD          (RsD),
        .RtD          (RtD),
        .HiLoReadD    (HiLoReadD),
        .Start_mult   (Start_mult),
        .mult_ready   (mult_ready),
        .BTFlush      (BTFlush),
        .JFlush       (JFlush),
        .stall        (stall),
        .flush        (flush),
        .hazard_lane  (hazard_lane),
        .mult_busy    (mult_busy),
        .stall_cycles (stall_cycles)
    );

    hazard_unit_nw #(
        .LANES        (2),
        .REG_W        (5),
        .FLUSH_CYCLES (1),
        .CNT_W        (4)
    ) dut_b (
        .clk          (clk),
        .reset        (reset),
        .MemToRegE    (MemToRegE),
        .RegDstE      (RegDstE),
        .RsD          (RsD),
        .RtD          (RtD),
        .HiLoReadD    (HiLoReadD),
        .Start_mult   (Start_mult),
        .mult_ready   (mult_ready),
        .BTFlush      (BTFlush),
        .JFlush       (JFlush),
        .stall        (stall_b),
        .flush        (flush_b),
        .hazard_lane  (hazard_lane_b),
        .mult_busy    (mult_busy_b),
        .stall_cycles (stall_cycles_b)
    );

    task automatic clear_inputs();
        MemToRegE  = '0;
        RegDstE    = '0;
        RsD        = '0;
        RtD        = '0;
        HiLoReadD  = '0;
        Start_mult = 1'b0;
        mult_ready = 1'b0;
        BTFlush    = 1'b0;
        JFlush     = 1'b0;
    endtask

    // Lane-0 load of $5, decode lane 1 reads $5
    task automatic set_load_use();
        MemToRegE = 2'b01;
        RegDstE   = {5'd0, 5'd5};
        RsD       = {5'd5, 5'd0};
        RtD       = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        set_load_use();
        HiLoReadD = 2'b11;
        BTFlush   = 1'b1;
        #1;
        checks++;
        if ({stall, flush, hazard_lane, mult_busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want 00000", {stall, flush, hazard_lane, mult_busy});
        end
        checks++;
        if (stall_cycles !== 16'd0 || stall_cycles_b !== 4'd0) begin
            errors++;
            $display("FAIL reset_counter: got %0d/%0d, want 0/0", stall_cycles, stall_cycles_b);
        end
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        #1;
        checks++;
        if ({stall, hazard_lane, flush} !== 4'b1100) begin
            errors++;
            $display("FAIL load_use_cross: got stall=%b hl=%b flush=%b, want 1 10 0", stall, hazard_lane, flush);
        end
        @(negedge clk);
        RegDstE = '0;
        RsD     = '0;
        #1;
        checks++;
        if (stall !== 1'b0 || hazard_lane !== 2'b00) begin
            errors++;
            $display("FAIL load_use_r0: got stall=%b hl=%b, want 0 00", stall, hazard_lane);
        end
        @(negedge clk);
        MemToRegE = 2'b10;
        RegDstE   = {5'd7, 5'd3};
        RtD       = {5'd0, 5'd7};
        #1;
        checks++;
        if (stall !== 1'b1 || hazard_lane !== 2'b01) begin
            errors++;
            $display("FAIL load_use_rt: got stall=%b hl=%b, want 1 01", stall, hazard_lane);
        end
        @(negedge clk);
        MemToRegE = 2'b00;
        #1;
        checks++;
        if (stall !== 1'b0 || hazard_lane !== 2'b00) begin
            errors++;
            $display("FAIL load_use_noload: got stall=%b hl=%b, want 0 00", stall, hazard_lane);
        end
        clear_inputs();
    endtask

    task automatic test_mult();
        do_reset();
        Start_mult = 1'b1;
        HiLoReadD  = 2'b01;
        #1;
        checks++;
        if (mult_busy !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL mult_start_cycle: got busy=%b stall=%b, want 0 0", mult_busy, stall);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            Start_mult = 1'b0;
            mult_ready = (i == 4);
            #1;
            checks++;
            if (mult_busy !== 1'b1 || stall !== 1'b1 || mult_busy_b !== 1'b1) begin
                errors++;
                $display("FAIL mult_busy_c%0d: got busy=%b stall=%b busy_b=%b, want 1 1 1", i, mult_busy, stall, mult_busy_b);
            end
        end
        @(negedge clk);
        mult_ready = 1'b0;
        #1;
        checks++;
        if (mult_busy !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL mult_done: got busy=%b stall=%b, want 0 0", mult_busy, stall);
        end
        checks++;
        if (stall_cycles !== 16'd4 || stall_cycles_b !== 4'd4) begin
            errors++;
            $display("FAIL mult_stall_count: got %0d/%0d, want 4/4", stall_cycles, stall_cycles_b);
        end
        // Start with ready in the same cycle stays idle
        Start_mult = 1'b1;
        mult_ready = 1'b1;
        @(negedge clk);
        Start_mult = 1'b0;
        mult_ready = 1'b0;
        #1;
        checks++;
        if (mult_busy !== 1'b0) begin
            errors++;
            $display("FAIL mult_start_ready: got busy=%b, want 0", mult_busy);
        end
        clear_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        set_load_use();
        BTFlush = 1'b1;
        #1;
        checks++;
        if ({flush, stall, hazard_lane} !== 4'b1000 || {flush_b, stall_b} !== 2'b10) begin
            errors++;
            $display("FAIL flush_t0: got f=%b s=%b hl=%b fb=%b sb=%b, want 1 0 00 1 0", flush, stall, hazard_lane, flush_b, stall_b);
        end
        @(negedge clk);
        BTFlush = 1'b0;
        #1;
        checks++;
        if ({flush, stall} !== 2'b10 || {flush_b, stall_b, hazard_lane_b} !== 4'b0110) begin
            errors++;
            $display("FAIL flush_t1: got f=%b s=%b fb=%b sb=%b hlb=%b, want 1 0 0 1 10", flush, stall, flush_b, stall_b, hazard_lane_b);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({flush, stall} !== 2'b10) begin
            errors++;
            $display("FAIL flush_t2: got f=%b s=%b, want 1 0", flush, stall);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({flush, stall, hazard_lane} !== 4'b0110) begin
            errors++;
            $display("FAIL flush_t3: got f=%b s=%b hl=%b, want 0 1 10", flush, stall, hazard_lane);
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [4:0] got;
        do_reset();
        for (int t = 0; t <= 4; t++) begin
            JFlush = (t <= 1);
            #1;
            got[t] = flush;
            @(negedge clk);
        end
        JFlush = 1'b0;
        checks++;
        if (got !== 5'b01111) begin
            errors++;
            $display("FAIL jump_reload: got flush t4..t0=%b, want 01111", got);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        Start_mult = 1'b1;
        @(negedge clk);
        Start_mult = 1'b0;
        BTFlush    = 1'b1;
        HiLoReadD  = 2'b10;
        @(negedge clk);
        BTFlush = 1'b0;
        set_load_use();
        #1;
        checks++;
        if (mult_busy !== 1'b1 || flush !== 1'b1) begin
            errors++;
            $display("FAIL mid_precondition: got busy=%b flush=%b, want 1 1", mult_busy, flush);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({stall, flush, hazard_lane, mult_busy} !== 5'b0 || stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: got outs=%b cnt=%0d, want 00000 0", {stall, flush, hazard_lane, mult_busy}, stall_cycles);
        end
        clear_inputs();
        mult_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mult_ready = 1'b0;
        HiLoReadD  = 2'b11;
        #1;
        checks++;
        if ({mult_busy, flush, stall} !== 3'b000) begin
            errors++;
            $display("FAIL mid_after: got busy=%b flush=%b stall=%b, want 0 0 0", mult_busy, flush, stall);
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        set_load_use();
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (stall_cycles_b !== 4'd15) begin
            errors++;
            $display("FAIL sat_cnt4: got %0d, want 15", stall_cycles_b);
        end
        checks++;
        if (stall_cycles !== 16'd20) begin
            errors++;
            $display("FAIL sat_cnt16: got %0d, want 20", stall_cycles);
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_mult();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
